id_ex_pipe_reg: RTL and testbench
=================================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register for the RV32IM 5-stage pipeline.
- Captures decoded operands, control bits and forwarding selects from ID; presents them to EX.
- Its ex_rd, ex_we and ex_memr outputs feed back into the ID-stage hazard logic.
- Applies the hazard logic's bubble, the EX-stage branch flush, and the multi-cycle MUL/DIV hold. Tracks a valid bit per slot.

Parameters:
- XLEN, 32, datapath width of pc/operand/immediate fields
- ALUOP_W, 5, width of ALU operation code
- FWD_W, 2, width of each forwarding select (00 ID, 01 EX, 10 MEM)

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID slot holds a real instruction
- id_pc  in  XLEN  PC of ID instruction
- id_data1  in  XLEN  rs1 register-file value
- id_data2  in  XLEN  rs2 register-file value
- id_imm  in  XLEN  decoded immediate
- id_rd  in  5  destination register
- id_aluop  in  ALUOP_W  ALU/MUL/DIV operation
- id_alusrc  in  1  operand-2 select (1 = imm)
- id_we  in  1  register write enable
- id_memr  in  1  load
- id_memw  in  1  store
- id_funct3  in  3  memory size/sign, branch condition
- id_branch  in  1  conditional branch
- id_jump  in  1  JAL/JALR
- id_fwd1sel  in  FWD_W  forwarding select rs1
- id_fwd2sel  in  FWD_W  forwarding select rs2
- bubble  in  1  insert NOP into EX (from hazard logic)
- flush  in  1  branch/jump taken in EX; kill ID instruction
- ex_hold  in  1  EX multi-cycle unit busy; freeze register
- ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rd, ex_aluop, ex_alusrc, ex_we, ex_memr, ex_memw, ex_funct3, ex_branch, ex_jump, ex_fwd1sel, ex_fwd2sel  out  widths as matching id_ inputs  registered copies
- perf_bubbles, perf_flushes, perf_holds  out  32 each  event counters (see Optional Feature)

Behaviour:
- All outputs are registered; ID-to-EX latency is 1 cycle. No combinational input-to-output path.
- Control fields: ex_valid, ex_we, ex_memr, ex_memw, ex_branch, ex_jump. The rest are data fields.
- Per-edge priority, exactly one applies:
  1. reset: every output is 0, counters included. Mid-operation reset discards the held instruction.
  2. flush: control fields are 0 and ex_rd is 0. Data fields keep their old values. Flush wins over hold and bubble.
  3. ex_hold: all fields keep their value, so the same instruction re-presents to EX. A bubble arriving in the same cycle is ignored; the hazard logic re-evaluates next cycle.
  4. bubble: same as flush (controls 0, ex_rd 0, data held).
  5. otherwise: load every field from id_*. ex_valid is id_valid.
- When a load leaves ex_valid=0, every control output is forced to 0, whatever the id_* control inputs are. An invalid slot never writes, loads or stores.
- ex_rd is 0 whenever ex_valid=0. This guarantees no false hazard match or forward in ID.
- The stall output of the hazard logic is not an input here. Stall freezes PC and IF/ID only, and bubble arrives in the same cycle.
- Back-to-back bubbles each produce one NOP cycle.
- Hold asserted for N cycles keeps the same ex_* for N+1 cycles in total, counting the original load cycle.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined: three 32-bit saturating counters, each incrementing by 1 on a clock edge where its event is the winning action (not held at 0xFFFFFFFF), and cleared by reset:
  - perf_bubbles
  - perf_flushes
  - perf_holds
- Undefined: the counters and their logic are not built, and the perf_* ports stay present, tied to 0.

Test Plan:
- Reset with all id_* = 0xFF..: after one edge every output is 0. Release, load id_pc=0x100, id_rd=5, id_we=1 -> next cycle ex_pc=0x100, ex_rd=5, ex_we=1, ex_valid=1.
- Load-use: ex holds lw x3. Assert bubble one cycle with id_rd=4, id_we=1 -> ex_valid=0, ex_we=0, ex_rd=0. Next cycle with bubble low -> ex_rd=4, ex_we=1.
- ex_hold 3 cycles with a div in EX (ex_aluop=DIV, ex_rd=7) while id_* changes -> ex_* unchanged for 3 cycles, then loads the new ID values.
- flush and ex_hold and bubble asserted together -> flush wins: ex_valid=0, ex_memw=0, ex_rd=0. With the macro defined: perf_flushes +1, perf_holds and perf_bubbles unchanged.
- id_valid=0 with id_memw=1, id_rd=9 -> ex_memw=0, ex_rd=0, ex_valid=0.
- Macro defined: preload perf_bubbles=0xFFFFFFFE by forcing state, then apply 3 bubbles -> counter saturates at 0xFFFFFFFF. Reset mid-run -> all counters 0.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX pipeline register bus.
// Groups the ID-stage inputs (decoded slot plus hazard/flush/hold
// controls) and the registered EX-stage outputs into one bundle.
// master : ID stage / hazard logic side (drives id_* and controls).
// slave  : the ID/EX register itself (drives ex_*).
interface id_ex_pipe_reg_if #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5,
  parameter int FWD_W   = 2
);

  // ID-stage slot
  logic               id_valid;
  logic [XLEN-1:0]    id_pc;
  logic [XLEN-1:0]    id_data1;
  logic [XLEN-1:0]    id_data2;
  logic [XLEN-1:0]    id_imm;
  logic [4:0]         id_rd;
  logic [ALUOP_W-1:0] id_aluop;
  logic               id_alusrc;
  logic               id_we;
  logic               id_memr;
  logic               id_memw;
  logic [2:0]         id_funct3;
  logic               id_branch;
  logic               id_jump;
  logic [FWD_W-1:0]   id_fwd1sel;
  logic [FWD_W-1:0]   id_fwd2sel;

  // pipeline controls
  logic               bubble;
  logic               flush;
  logic               ex_hold;

  // EX-stage slot
  logic               ex_valid;
  logic [XLEN-1:0]    ex_pc;
  logic [XLEN-1:0]    ex_data1;
  logic [XLEN-1:0]    ex_data2;
  logic [XLEN-1:0]    ex_imm;
  logic [4:0]         ex_rd;
  logic [ALUOP_W-1:0] ex_aluop;
  logic               ex_alusrc;
  logic               ex_we;
  logic               ex_memr;
  logic               ex_memw;
  logic [2:0]         ex_funct3;
  logic               ex_branch;
  logic               ex_jump;
  logic [FWD_W-1:0]   ex_fwd1sel;
  logic [FWD_W-1:0]   ex_fwd2sel;

  modport master (
    output id_valid, id_pc, id_data1, id_data2, id_imm, id_rd, id_aluop,
           id_alusrc, id_we, id_memr, id_memw, id_funct3, id_branch,
           id_jump, id_fwd1sel, id_fwd2sel, bubble, flush, ex_hold,
    input  ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rd, ex_aluop,
           ex_alusrc, ex_we, ex_memr, ex_memw, ex_funct3, ex_branch,
           ex_jump, ex_fwd1sel, ex_fwd2sel
  );

  modport slave (
    input  id_valid, id_pc, id_data1, id_data2, id_imm, id_rd, id_aluop,
           id_alusrc, id_we, id_memr, id_memw, id_funct3, id_branch,
           id_jump, id_fwd1sel, id_fwd2sel, bubble, flush, ex_hold,
    output ex_valid, ex_pc, ex_data1, ex_data2, ex_imm, ex_rd, ex_aluop,
           ex_alusrc, ex_we, ex_memr, ex_memw, ex_funct3, ex_branch,
           ex_jump, ex_fwd1sel, ex_fwd2sel
  );

endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register for the RV32IM 5-stage pipeline.
// Per edge exactly one action applies, in priority order:
//   reset > flush > ex_hold > bubble > load.
// Flush and bubble both turn the slot into a NOP (controls and ex_rd
// cleared, data fields left as they were); hold freezes everything so a
// multi-cycle MUL/DIV keeps seeing the same instruction.
// An invalid slot always presents zero controls and ex_rd = 0, so the
// ID-stage hazard/forwarding compare can never match a dead slot.
// Optional build macro ID_EX_PERF_CNT_EN adds three saturating event
// counters (bubbles, flushes, holds); without it the perf ports read 0.
module id_ex_pipe_reg #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5,
  parameter int FWD_W   = 2
) (
  input  logic        clk,
  input  logic        reset,
  id_ex_pipe_reg_if.slave bus,
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_flushes,
  output logic [31:0] perf_holds
);

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2,
    ACT_FLUSH  = 2'd3
  } action_e;

  action_e action;

  // slot registers
  logic               valid_q,  valid_d;
  logic [XLEN-1:0]    pc_q,     pc_d;
  logic [XLEN-1:0]    data1_q,  data1_d;
  logic [XLEN-1:0]    data2_q,  data2_d;
  logic [XLEN-1:0]    imm_q,    imm_d;
  logic [4:0]         rd_q,     rd_d;
  logic [ALUOP_W-1:0] aluop_q,  aluop_d;
  logic               alusrc_q, alusrc_d;
  logic               we_q,     we_d;
  logic               memr_q,   memr_d;
  logic               memw_q,   memw_d;
  logic [2:0]         funct3_q, funct3_d;
  logic               branch_q, branch_d;
  logic               jump_q,   jump_d;
  logic [FWD_W-1:0]   fwd1_q,   fwd1_d;
  logic [FWD_W-1:0]   fwd2_q,   fwd2_d;

  // Pick the single winning action for this edge (reset handled in the flops).
  always_comb begin
    action = ACT_LOAD;
    if (bus.flush) begin
      action = ACT_FLUSH;
    end else if (bus.ex_hold) begin
      action = ACT_HOLD;
    end else if (bus.bubble) begin
      action = ACT_BUBBLE;
    end else begin
      action = ACT_LOAD;
    end
  end

  // Next-state for every slot field according to the winning action.
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    data1_d  = data1_q;
    data2_d  = data2_q;
    imm_d    = imm_q;
    rd_d     = rd_q;
    aluop_d  = aluop_q;
    alusrc_d = alusrc_q;
    we_d     = we_q;
    memr_d   = memr_q;
    memw_d   = memw_q;
    funct3_d = funct3_q;
    branch_d = branch_q;
    jump_d   = jump_q;
    fwd1_d   = fwd1_q;
    fwd2_d   = fwd2_q;
    case (action)
      ACT_LOAD: begin
        // Data fields load unconditionally; controls and rd are gated by
        // id_valid so a dead slot can never write, load, store or match.
        valid_d  = bus.id_valid;
        pc_d     = bus.id_pc;
        data1_d  = bus.id_data1;
        data2_d  = bus.id_data2;
        imm_d    = bus.id_imm;
        aluop_d  = bus.id_aluop;
        alusrc_d = bus.id_alusrc;
        funct3_d = bus.id_funct3;
        fwd1_d   = bus.id_fwd1sel;
        fwd2_d   = bus.id_fwd2sel;
        if (bus.id_valid) begin
          rd_d     = bus.id_rd;
          we_d     = bus.id_we;
          memr_d   = bus.id_memr;
          memw_d   = bus.id_memw;
          branch_d = bus.id_branch;
          jump_d   = bus.id_jump;
        end else begin
          rd_d     = 5'd0;
          we_d     = 1'b0;
          memr_d   = 1'b0;
          memw_d   = 1'b0;
          branch_d = 1'b0;
          jump_d   = 1'b0;
        end
      end
      ACT_HOLD: begin
        // Everything keeps its value (defaults above).
        valid_d  = valid_q;
      end
      ACT_BUBBLE, ACT_FLUSH: begin
        // Turn the slot into a NOP; data fields are don't-care and held.
        valid_d  = 1'b0;
        rd_d     = 5'd0;
        we_d     = 1'b0;
        memr_d   = 1'b0;
        memw_d   = 1'b0;
        branch_d = 1'b0;
        jump_d   = 1'b0;
      end
      default: begin
        valid_d  = valid_q;
      end
    endcase
  end

  // Slot register with synchronous reset clearing every field.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      pc_q     <= {XLEN{1'b0}};
      data1_q  <= {XLEN{1'b0}};
      data2_q  <= {XLEN{1'b0}};
      imm_q    <= {XLEN{1'b0}};
      rd_q     <= 5'd0;
      aluop_q  <= {ALUOP_W{1'b0}};
      alusrc_q <= 1'b0;
      we_q     <= 1'b0;
      memr_q   <= 1'b0;
      memw_q   <= 1'b0;
      funct3_q <= 3'd0;
      branch_q <= 1'b0;
      jump_q   <= 1'b0;
      fwd1_q   <= {FWD_W{1'b0}};
      fwd2_q   <= {FWD_W{1'b0}};
    end else begin
      valid_q  <= valid_d;
      pc_q     <= pc_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      imm_q    <= imm_d;
      rd_q     <= rd_d;
      aluop_q  <= aluop_d;
      alusrc_q <= alusrc_d;
      we_q     <= we_d;
      memr_q   <= memr_d;
      memw_q   <= memw_d;
      funct3_q <= funct3_d;
      branch_q <= branch_d;
      jump_q   <= jump_d;
      fwd1_q   <= fwd1_d;
      fwd2_q   <= fwd2_d;
    end
  end

  assign bus.ex_valid   = valid_q;
  assign bus.ex_pc      = pc_q;
  assign bus.ex_data1   = data1_q;
  assign bus.ex_data2   = data2_q;
  assign bus.ex_imm     = imm_q;
  assign bus.ex_rd      = rd_q;
  assign bus.ex_aluop   = aluop_q;
  assign bus.ex_alusrc  = alusrc_q;
  assign bus.ex_we      = we_q;
  assign bus.ex_memr    = memr_q;
  assign bus.ex_memw    = memw_q;
  assign bus.ex_funct3  = funct3_q;
  assign bus.ex_branch  = branch_q;
  assign bus.ex_jump    = jump_q;
  assign bus.ex_fwd1sel = fwd1_q;
  assign bus.ex_fwd2sel = fwd2_q;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic [31:0] perf_flushes_q, perf_flushes_d;
  logic [31:0] perf_holds_q,   perf_holds_d;

  // Saturating increment of the counter matching the winning action.
  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_flushes_d = perf_flushes_q;
    perf_holds_d   = perf_holds_q;
    case (action)
      ACT_BUBBLE: begin
        if (perf_bubbles_q != 32'hFFFF_FFFF) begin
          perf_bubbles_d = perf_bubbles_q + 32'd1;
        end else begin
          perf_bubbles_d = perf_bubbles_q;
        end
      end
      ACT_FLUSH: begin
        if (perf_flushes_q != 32'hFFFF_FFFF) begin
          perf_flushes_d = perf_flushes_q + 32'd1;
        end else begin
          perf_flushes_d = perf_flushes_q;
        end
      end
      ACT_HOLD: begin
        if (perf_holds_q != 32'hFFFF_FFFF) begin
          perf_holds_d = perf_holds_q + 32'd1;
        end else begin
          perf_holds_d = perf_holds_q;
        end
      end
      default: begin
        perf_holds_d = perf_holds_q;
      end
    endcase
  end

  // Event counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_bubbles_q <= 32'd0;
      perf_flushes_q <= 32'd0;
      perf_holds_q   <= 32'd0;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_flushes_q <= perf_flushes_d;
      perf_holds_q   <= perf_holds_d;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_flushes = perf_flushes_q;
  assign perf_holds   = perf_holds_q;
`else
  assign perf_bubbles = 32'd0;
  assign perf_flushes = 32'd0;
  assign perf_holds   = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed scoreboard bench for id_ex_pipe_reg.
module tb_id_ex_pipe_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [4:0]  aluop;
    logic        alusrc;
    logic        we;
    logic        memr;
    logic        memw;
    logic [2:0]  funct3;
    logic        branch;
    logic        jump;
    logic [1:0]  f1;
    logic [1:0]  f2;
  } slot_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] perf_b, perf_f, perf_h;

  id_ex_pipe_reg_if #(.XLEN(32), .ALUOP_W(5), .FWD_W(2)) bus ();

  id_ex_pipe_reg #(.XLEN(32), .ALUOP_W(5), .FWD_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus.slave),
    .perf_bubbles (perf_b),
    .perf_flushes (perf_f),
    .perf_holds   (perf_h)
  );

  always #5 clk = ~clk;

  int    n_asserts = 0;
  int    n_fail    = 0;
  slot_t exp_q[$];
  slot_t last;
  slot_t idv;
  logic [31:0] exp_bub = 32'd0;
  logic [31:0] exp_fl  = 32'd0;
  logic [31:0] exp_hd  = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // expected slot after loading s (invalid slot: no controls, rd 0)
  function automatic slot_t gate(input slot_t s);
    slot_t r = s;
    if (!s.valid) begin
      r.rd = 5'd0; r.we = 1'b0; r.memr = 1'b0; r.memw = 1'b0;
      r.branch = 1'b0; r.jump = 1'b0;
    end
    return r;
  endfunction

  // expected slot after a bubble/flush: NOP, data held
  function automatic slot_t kill(input slot_t s);
    slot_t r = s;
    r.valid = 1'b0; r.rd = 5'd0; r.we = 1'b0; r.memr = 1'b0; r.memw = 1'b0;
    r.branch = 1'b0; r.jump = 1'b0;
    return r;
  endfunction

  task automatic drive_id();
    bus.id_valid = idv.valid;  bus.id_pc = idv.pc;       bus.id_data1 = idv.d1;
    bus.id_data2 = idv.d2;     bus.id_imm = idv.imm;     bus.id_rd = idv.rd;
    bus.id_aluop = idv.aluop;  bus.id_alusrc = idv.alusrc; bus.id_we = idv.we;
    bus.id_memr = idv.memr;    bus.id_memw = idv.memw;   bus.id_funct3 = idv.funct3;
    bus.id_branch = idv.branch; bus.id_jump = idv.jump;
    bus.id_fwd1sel = idv.f1;   bus.id_fwd2sel = idv.f2;
  endtask

  task automatic push(input slot_t e);
    exp_q.push_back(e);
    last = e;
  endtask

  // advance one edge, then pop the scoreboard and compare
  task automatic tick(input string tag);
    slot_t e;
    @(posedge clk);
    #1;
    n_asserts++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, ".valid"},  {31'd0, bus.ex_valid},  {31'd0, e.valid});
      chk({tag, ".pc"},     bus.ex_pc,    e.pc);
      chk({tag, ".data1"},  bus.ex_data1, e.d1);
      chk({tag, ".data2"},  bus.ex_data2, e.d2);
      chk({tag, ".imm"},    bus.ex_imm,   e.imm);
      chk({tag, ".rd"},     {27'd0, bus.ex_rd},    {27'd0, e.rd});
      chk({tag, ".aluop"},  {27'd0, bus.ex_aluop}, {27'd0, e.aluop});
      chk({tag, ".alusrc"}, {31'd0, bus.ex_alusrc}, {31'd0, e.alusrc});
      chk({tag, ".we"},     {31'd0, bus.ex_we},     {31'd0, e.we});
      chk({tag, ".memr"},   {31'd0, bus.ex_memr},   {31'd0, e.memr});
      chk({tag, ".memw"},   {31'd0, bus.ex_memw},   {31'd0, e.memw});
      chk({tag, ".funct3"}, {29'd0, bus.ex_funct3}, {29'd0, e.funct3});
      chk({tag, ".branch"}, {31'd0, bus.ex_branch}, {31'd0, e.branch});
      chk({tag, ".jump"},   {31'd0, bus.ex_jump},   {31'd0, e.jump});
      chk({tag, ".fwd1"},   {30'd0, bus.ex_fwd1sel}, {30'd0, e.f1});
      chk({tag, ".fwd2"},   {30'd0, bus.ex_fwd2sel}, {30'd0, e.f2});
    end
`ifdef ID_EX_PERF_CNT_EN
    chk({tag, ".perf_bubbles"}, perf_b, exp_bub);
    chk({tag, ".perf_flushes"}, perf_f, exp_fl);
    chk({tag, ".perf_holds"},   perf_h, exp_hd);
`else
    chk({tag, ".perf_bubbles"}, perf_b, 32'd0);
    chk({tag, ".perf_flushes"}, perf_f, 32'd0);
    chk({tag, ".perf_holds"},   perf_h, 32'd0);
`endif
  endtask

  task automatic do_load(input string tag);
    drive_id();
    push(gate(idv));
    tick(tag);
  endtask

  task automatic do_bubble(input string tag);
    drive_id();
    bus.bubble = 1'b1;
    push(kill(last));
    exp_bub = sat_inc(exp_bub);
    tick(tag);
    bus.bubble = 1'b0;
  endtask

  initial begin
    slot_t zero;
    zero = '0;
    // Reset with every id input all-ones
    reset = 1'b1;
    bus.bubble = 1'b0; bus.flush = 1'b0; bus.ex_hold = 1'b0;
    idv = '1;
    drive_id();
    push(zero);
    tick("reset");

    // Simple load after reset release
    reset = 1'b0;
    idv = '0;
    idv.valid = 1'b1; idv.pc = 32'h100; idv.rd = 5'd5; idv.we = 1'b1;
    idv.d1 = 32'h1111_0001; idv.d2 = 32'h2222_0002; idv.imm = 32'h0000_0010;
    idv.aluop = 5'd3; idv.alusrc = 1'b1; idv.f1 = 2'b01; idv.f2 = 2'b10;
    do_load("load1");

    // Load-use: lw x3 in EX, then bubble with next instr in ID
    idv = '0;
    idv.valid = 1'b1; idv.pc = 32'h104; idv.rd = 5'd3; idv.we = 1'b1;
    idv.memr = 1'b1; idv.funct3 = 3'd2; idv.d1 = 32'h0000_8000; idv.imm = 32'h4;
    idv.alusrc = 1'b1;
    do_load("lw_x3");
    idv = '0;
    idv.valid = 1'b1; idv.pc = 32'h108; idv.rd = 5'd4; idv.we = 1'b1;
    idv.d1 = 32'hABCD_0000; idv.aluop = 5'd1; idv.f1 = 2'b01;
    do_bubble("loaduse_bubble");
    do_load("loaduse_reload");

    // Back-to-back bubbles: one NOP each
    do_bubble("b2b_bubble1");
    do_bubble("b2b_bubble2");
    do_load("b2b_reload");

    // DIV held for 3 cycles while ID keeps changing
    idv = '0;
    idv.valid = 1'b1; idv.pc = 32'h200; idv.rd = 5'd7; idv.we = 1'b1;
    idv.aluop = 5'd12; idv.d1 = 32'd100; idv.d2 = 32'd7; idv.f2 = 2'b10;
    do_load("div_load");
    bus.ex_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idv.pc = 32'h300 + 32'(i * 4); idv.rd = 5'(20 + i); idv.aluop = 5'(i);
      idv.d1 = 32'hDEAD_0000 + 32'(i); idv.memw = 1'b1; idv.jump = 1'(i & 1);
      drive_id();
      bus.bubble = (i == 1) ? 1'b1 : 1'b0;   // bubble under hold is ignored
      push(last);
      exp_hd = sat_inc(exp_hd);
      tick("div_hold");
    end
    bus.ex_hold = 1'b0;
    bus.bubble = 1'b0;
    do_load("div_release");

    // Store in EX, then flush + hold + bubble together: flush wins
    idv = '0;
    idv.valid = 1'b1; idv.pc = 32'h400; idv.rd = 5'd6; idv.memw = 1'b1;
    idv.funct3 = 3'd2; idv.d2 = 32'h5A5A_5A5A; idv.branch = 1'b1;
    do_load("store_load");
    idv.pc = 32'h404; idv.rd = 5'd8; idv.we = 1'b1;
    drive_id();
    bus.flush = 1'b1; bus.ex_hold = 1'b1; bus.bubble = 1'b1;
    push(kill(last));
    exp_fl = sat_inc(exp_fl);
    tick("flush_all");
    bus.flush = 1'b0; bus.ex_hold = 1'b0; bus.bubble = 1'b0;

    // Invalid ID slot: controls and rd forced off
    idv = '0;
    idv.valid = 1'b0; idv.memw = 1'b1; idv.rd = 5'd9; idv.we = 1'b1;
    idv.memr = 1'b1; idv.branch = 1'b1; idv.jump = 1'b1; idv.pc = 32'h500;
    idv.d1 = 32'h0BAD_F00D;
    do_load("invalid_slot");

    // Jump instruction, valid
    idv = '0;
    idv.valid = 1'b1; idv.pc = 32'h600; idv.rd = 5'd1; idv.we = 1'b1;
    idv.jump = 1'b1; idv.imm = 32'hFFFF_FFF0; idv.f1 = 2'b10;
    do_load("jal_load");

`ifdef ID_EX_PERF_CNT_EN
    // Counter saturation: preload near max, then three bubbles
    @(negedge clk);
    force dut.perf_bubbles_q = 32'hFFFF_FFFE;
    #1;
    release dut.perf_bubbles_q;
    exp_bub = 32'hFFFF_FFFE;
    do_bubble("sat_bubble1");
    do_bubble("sat_bubble2");
    do_bubble("sat_bubble3");
`endif

    // Reset mid-run with a valid instruction in EX
    do_load("pre_reset_load");
    reset = 1'b1;
    bus.ex_hold = 1'b1;
    push(zero);
    exp_bub = 32'd0; exp_fl = 32'd0; exp_hd = 32'd0;
    tick("midrun_reset");
    reset = 1'b0;
    bus.ex_hold = 1'b0;
    do_load("post_reset_load");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
